// File: rtl/grayscale_pipe.sv
// Two-stage RGB-to-grayscale pipeline between an FWFT pixel FIFO and a gray FIFO.
// Per-pixel mode selects plain average or BT.601-style weighted luma.
module grayscale_pipe #(
  parameter int CHAN_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    in_rd_en,
  input  logic                    in_empty,
  input  logic [3*CHAN_WIDTH-1:0] in_dout,
  input  logic                    mode,
  output logic                    out_wr_en,
  input  logic                    out_full,
  output logic [CHAN_WIDTH-1:0]   out_din,
  output logic [CNT_WIDTH-1:0]    pix_count
);

  localparam int SW = CHAN_WIDTH + 2;
  localparam int PW = CHAN_WIDTH + 10;
  localparam logic [PW-1:0] W_R = PW'(77);
  localparam logic [PW-1:0] W_G = PW'(150);
  localparam logic [PW-1:0] W_B = PW'(29);

  logic                  s1_v_q, s1_v_d;
  logic [CHAN_WIDTH-1:0] s1_r_q, s1_r_d;
  logic [CHAN_WIDTH-1:0] s1_g_q, s1_g_d;
  logic [CHAN_WIDTH-1:0] s1_b_q, s1_b_d;
  logic                  s1_mode_q, s1_mode_d;
  logic                  s2_v_q, s2_v_d;
  logic [CHAN_WIDTH-1:0] s2_gray_q, s2_gray_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  en;
  logic [SW-1:0]         sum_avg;
  logic [PW-1:0]         sum_wt;
  logic [CHAN_WIDTH-1:0] gray_avg;
  logic [CHAN_WIDTH-1:0] gray_wt;
  logic [CHAN_WIDTH-1:0] gray_s1;

  // A bubble in S2 never blocks, so only a valid sample facing a full FIFO stalls.
  assign en        = ~(s2_v_q & out_full);
  assign in_rd_en  = ~reset & ~in_empty & en;
  assign out_wr_en = ~reset & s2_v_q & ~out_full;
  assign out_din   = s2_gray_q;
  assign pix_count = cnt_q;

  always_comb begin
    sum_avg  = SW'(s1_r_q) + SW'(s1_g_q) + SW'(s1_b_q);
    sum_wt   = W_R * PW'(s1_r_q) + W_G * PW'(s1_g_q) + W_B * PW'(s1_b_q);
    gray_avg = CHAN_WIDTH'(sum_avg / SW'(3));
    gray_wt  = CHAN_WIDTH'(sum_wt >> 8);
    gray_s1  = s1_mode_q ? gray_wt : gray_avg;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_r_d    = s1_r_q;
    s1_g_d    = s1_g_q;
    s1_b_d    = s1_b_q;
    s1_mode_d = s1_mode_q;
    s2_v_d    = s2_v_q;
    s2_gray_d = s2_gray_q;
    cnt_d     = cnt_q;
    if (en) begin
      s1_v_d = in_rd_en;
      if (in_rd_en) begin
        s1_r_d    = in_dout[3*CHAN_WIDTH-1:2*CHAN_WIDTH];
        s1_g_d    = in_dout[2*CHAN_WIDTH-1:CHAN_WIDTH];
        s1_b_d    = in_dout[CHAN_WIDTH-1:0];
        s1_mode_d = mode;
      end
      s2_v_d    = s1_v_q;
      s2_gray_d = gray_s1;
    end
    if (out_wr_en) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      s1_mode_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_gray_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_r_q    <= s1_r_d;
      s1_g_q    <= s1_g_d;
      s1_b_q    <= s1_b_d;
      s1_mode_q <= s1_mode_d;
      s2_v_q    <= s2_v_d;
      s2_gray_q <= s2_gray_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Scoreboard bench for grayscale_pipe: driver feeds an FWFT source model,
// monitor pops expected gray samples from a queue on every push.
module tb_grayscale_pipe;

  typedef struct {
    logic [23:0] pix;
    bit          m;
  } px_t;

  typedef struct {
    int val;
    int pop_cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_rd_en, in_rd_en_w;
  logic        in_empty;
  logic [23:0] in_dout;
  logic        mode;
  logic        out_wr_en, out_wr_en_w;
  logic        out_full;
  logic [7:0]  out_din, out_din_w;
  logic [31:0] pix_count;
  logic [3:0]  pix_count_w;

  grayscale_pipe #(.CHAN_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty),
    .in_dout(in_dout), .mode(mode), .out_wr_en(out_wr_en), .out_full(out_full),
    .out_din(out_din), .pix_count(pix_count)
  );

  grayscale_pipe #(.CHAN_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en_w), .in_empty(in_empty),
    .in_dout(in_dout), .mode(mode), .out_wr_en(out_wr_en_w), .out_full(out_full),
    .out_din(out_din_w), .pix_count(pix_count_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int      cyc = 0;
  int      last_full = -1000;
  int      n_pass = 0;
  int      n_total = 0;
  longint  model_cnt = 0;
  px_t     src_q[$];
  exp_t    exp_q[$];
  int      got_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, req);
  endtask

  // Reference: integer arithmetic straight from the conversion formulas.
  function automatic int ref_gray(input logic [23:0] p, input bit m);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (m) return (77 * r + 150 * g + 29 * b) / 256;
    return (r + g + b) / 3;
  endfunction

  // Monitor: samples mid-cycle, so the values seen hold through the next rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (out_full) last_full = cyc;
    chk("pix_count", pix_count == model_cnt[31:0], pix_count, model_cnt[31:0]);
    chk("pix_count_w4", pix_count_w == model_cnt[3:0], pix_count_w, model_cnt[3:0]);
    if (reset) begin
      chk("rd_en_in_reset", in_rd_en == 1'b0, in_rd_en, 0);
      chk("wr_en_in_reset", out_wr_en == 1'b0, out_wr_en, 0);
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (out_full) chk("full_blocks_push", out_wr_en == 1'b0, out_wr_en, 0);
      if (out_full && exp_q.size() >= 2)
        chk("stall_no_pop", in_rd_en == 1'b0, in_rd_en, 0);
      if (exp_q.size() > 0 && exp_q[0].pop_cyc + 2 == cyc && last_full < exp_q[0].pop_cyc)
        chk("latency2", out_wr_en == 1'b1, out_wr_en, 1);
      if (out_wr_en) begin
        chk("push_expected", exp_q.size() != 0, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("gray_data", int'(out_din) == e.val, out_din, e.val);
          got_q.push_back(int'(out_din));
          model_cnt = model_cnt + 1;
        end
      end
      if (in_rd_en) begin
        e.val = ref_gray(in_dout, mode);
        e.pop_cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input bit gap, input bit full, input bit rst);
    bit popped;
    reset    = rst;
    out_full = full;
    if (src_q.size() > 0 && !gap) begin
      in_empty = 1'b0;
      in_dout  = src_q[0].pix;
      mode     = src_q[0].m;
    end else begin
      in_empty = 1'b1;
      in_dout  = 24'($urandom);
      mode     = 1'($urandom);
    end
    @(negedge clock);
    popped = in_rd_en;
    @(posedge clock);
    #1;
    if (popped) void'(src_q.pop_front());
  endtask

  task automatic add_px(input int r, input int g, input int b, input bit m);
    px_t p;
    p.pix = {8'(r), 8'(g), 8'(b)};
    p.m   = m;
    src_q.push_back(p);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && k < limit) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("drain_done", src_q.size() == 0 && exp_q.size() == 0, exp_q.size() + src_q.size(), 0);
  endtask

  task automatic check_got(input string nm, input int e[$]);
    chk({nm, "_count"}, got_q.size() == e.size(), got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++)
      chk(nm, got_q[i] == e[i], got_q[i], e[i]);
  endtask

  initial begin
    int ev[$];
    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = '0;
    mode     = 1'b0;
    out_full = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("reset_out_din", out_din == 8'd0, out_din, 0);
    chk("reset_wr_en", out_wr_en == 1'b0, out_wr_en, 0);
    chk("reset_pix_count", pix_count == 32'd0, pix_count, 0);

    // Back-to-back average stream.
    got_q.delete();
    add_px(255, 255, 255, 0);
    add_px(10, 20, 31, 0);
    add_px(0, 0, 0, 0);
    drain(20);
    ev = '{255, 20, 0};
    check_got("stream_avg", ev);
    chk("stream_pix_count", pix_count == 32'd3, pix_count, 3);

    // Weighted primaries.
    got_q.delete();
    add_px(255, 0, 0, 1);
    add_px(0, 255, 0, 1);
    add_px(0, 0, 255, 1);
    add_px(100, 100, 100, 1);
    drain(20);
    ev = '{76, 149, 28, 100};
    check_got("weighted", ev);

    // Same pixel, mode switched between pops.
    got_q.delete();
    add_px(30, 60, 90, 0);
    add_px(30, 60, 90, 1);
    drain(20);
    ev = '{60, 54};
    check_got("per_pixel_mode", ev);

    // Backpressure window mid-stream.
    got_q.delete();
    for (int i = 0; i < 8; i++)
      add_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    for (int i = 0; i < 12; i++) step(1'b0, (i >= 3 && i < 8), 1'b0);
    drain(30);
    chk("bp_all_arrived", got_q.size() == 8, got_q.size(), 8);

    // Input gaps every other cycle.
    for (int i = 0; i < 10; i++)
      add_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    for (int i = 0; i < 20; i++) step(1'(i % 2), 1'b0, 1'b0);
    drain(30);

    // Random traffic, gaps and backpressure.
    for (int i = 0; i < 300; i++) begin
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1)
        add_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0);
    end
    drain(50);

    // Reset with two pixels held in flight.
    got_q.delete();
    add_px(1, 2, 3, 0);
    add_px(4, 5, 6, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk("reset_inflight_popped", src_q.size() == 0, src_q.size(), 0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    chk("no_push_after_reset", got_q.size() == 0, got_q.size(), 0);
    chk("reset_clears_count", pix_count == 32'd0, pix_count, 0);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++)
      add_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    drain(40);
    chk("count_17", pix_count == 32'd17, pix_count, 17);
    chk("count_w4_wrap", pix_count_w == 4'd1, pix_count_w, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
